regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two >= 2; AW = log2(NREGS).
REQ-003 SHALL have parameter NRP, default 2, read port count.
REQ-004 SHALL have parameter NWP, default 2, write port count.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rd_addr_i  in  NRP*AW  read addresses, port p at bits [p*AW +: AW].
REQ-008 SHALL have port rd_data_o  out  NRP*XLEN  read data per port.
REQ-009 SHALL have port rd_busy_o  out  NRP  target register has pending write.
REQ-010 SHALL have port wr_en_i  in  NWP  write enables.
REQ-011 SHALL have port wr_addr_i  in  NWP*AW  write addresses.
REQ-012 SHALL have port wr_data_i  in  NWP*XLEN  write data.
REQ-013 SHALL have port rsv_valid_i  in  1  request to mark a destination busy.
REQ-014 SHALL have port rsv_addr_i  in  AW  destination to reserve.
REQ-015 SHALL have port rsv_ready_o  out  1  reservation accepted this cycle.
REQ-016 SHALL have port flush_i  in  1  discard all pending reservations.

Function
REQ-017 SHALL return register 0 as zero on every read port; register 0 SHALL never be written, reserved, or busy.
REQ-018 SHALL read combinationally: rd_data_o[p] = regs[rd_addr_i[p]], zero latency.
REQ-019 SHALL write regs[wr_addr_i[w]] <= wr_data_i[w] on the clock edge when wr_en_i[w] and address != 0.
REQ-020 SHALL, when several write ports hit one address in the same cycle, commit the highest-indexed port's data.
REQ-021 SHALL keep busy[NREGS]; reservation handshake completes when rsv_valid_i && rsv_ready_o, setting busy[rsv_addr_i] on that edge.
REQ-022 SHALL drive rsv_ready_o = 1 when rsv_addr_i == 0 (accepted, no effect) or busy[rsv_addr_i] == 0; 0 otherwise (WAW stall), independent of rsv_valid_i.
REQ-023 SHALL clear busy[a] on the edge of any enabled write to a.
REQ-024 SHALL, when a reservation set and a write clear hit the same address in one cycle, leave busy set (reservation is newer).
REQ-025 SHALL, on flush_i, clear every busy bit on that edge; flush overrides a same-cycle reservation; register writes still commit.
REQ-026 SHALL drive rd_busy_o[p] = busy[rd_addr_i[p]], 0 for address 0.

Reset
REQ-027 SHALL, while rst is high, clear all registers and busy bits asynchronously.
REQ-028 SHALL, while rst is high, force rd_data_o = 0, rd_busy_o = 0, rsv_ready_o = 0.
REQ-029 SHALL ignore writes, reservations and flush during reset; first accepted operation is on the first edge after rst falls.

Configuration
REQ-030 SHALL, with REGFILE_SB_BYPASS_EN defined, return same-cycle enabled write data on a matching nonzero read address (highest write port wins) and drive rd_busy_o[p] = 0 for that port in that cycle.
REQ-031 SHALL, without REGFILE_SB_BYPASS_EN, return pre-edge register contents and busy state, no forwarding logic present.

Structure
REQ-032 SHALL take XLEN/NREGS defaults and the register-address typedef from shared package regfile_pkg.
REQ-033 SHALL place busy-bit set/clear/flush logic and rsv_ready_o in sub-module regfile_scoreboard; storage and read muxing stay in regfile_sb.

Verification
REQ-034 SHALL cover: write port0 r5=0x1234_5678, next cycle read r5 on both ports -> 0x1234_5678; write r0=0xFFFF_FFFF -> r0 reads 0.
REQ-035 SHALL cover: port0 writes r7=0xAAAA_0000 and port1 writes r7=0x0000_5555 same cycle -> r7 = 0x0000_5555.
REQ-036 SHALL cover: reserve r3 -> rd_busy_o=1 for r3 next cycle; reserve r3 again -> rsv_ready_o=0; write r3=0x42 -> busy clears, rsv_ready_o=1.
REQ-037 SHALL cover: reserve r9 and write r9=0x9 same cycle -> r9=0x9, busy[r9]=1; then flush_i -> all rd_busy_o=0.
REQ-038 SHALL cover: with REGFILE_SB_BYPASS_EN, write r4=0xDEAD_BEEF while reading r4 -> same-cycle rd_data_o=0xDEAD_BEEF, rd_busy_o=0; without macro -> old value.
REQ-039 SHALL cover: assert rst mid-sequence with r2 busy and holding 0x77 -> immediately r2 reads 0, rd_busy_o=0, rsv_ready_o=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the register-address type for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservations set a bit, writes clear it, flush clears all.
module regfile_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NWP   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWP-1:0]    wr_en_i,
  input  logic [NWP*AW-1:0] wr_addr_i,
  input  logic              rsv_valid_i,
  input  logic [AW-1:0]     rsv_addr_i,
  input  logic              flush_i,
  output logic              rsv_ready_o,
  output logic [NREGS-1:0]  busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  // A busy destination stalls a second reservation (WAW); r0 is always accepted.
  assign rsv_ready_o = !rst && ((rsv_addr_i == '0) || !busy_q[rsv_addr_i]);
  assign busy_o      = busy_q;

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWP; w++) begin
      if (wr_en_i[w]) busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
    end
    // Set after clear: a same-cycle reservation is newer than the write it races.
    if (rsv_valid_i && rsv_ready_o) busy_d[rsv_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with busy scoreboard; r0 is hard-wired to zero.
// Optional same-cycle write-to-read forwarding with REGFILE_SB_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRP   = 2,
  parameter int unsigned NWP   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_addr_i,
  output logic [NRP*XLEN-1:0] rd_data_o,
  output logic [NRP-1:0]      rd_busy_o,
  input  logic [NWP-1:0]      wr_en_i,
  input  logic [NWP*AW-1:0]   wr_addr_i,
  input  logic [NWP*XLEN-1:0] wr_data_i,
  input  logic                rsv_valid_i,
  input  logic [AW-1:0]       rsv_addr_i,
  output logic                rsv_ready_o,
  input  logic                flush_i
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS(NREGS),
    .NWP  (NWP),
    .AW   (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .rsv_valid_i(rsv_valid_i),
    .rsv_addr_i (rsv_addr_i),
    .flush_i    (flush_i),
    .rsv_ready_o(rsv_ready_o),
    .busy_o     (busy)
  );

  // Later ports are assigned last, so the highest-indexed writer wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
          regs_q[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NRP; p++) begin
      rd_data_o[p*XLEN +: XLEN] = regs_q[rd_addr_i[p*AW +: AW]];
      rd_busy_o[p]              = busy[rd_addr_i[p*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
      for (int w = 0; w < NWP; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW]) &&
            (rd_addr_i[p*AW +: AW] != '0)) begin
          rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
          rd_busy_o[p]              = 1'b0;
        end
      end
`endif
    end
    if (rst) begin
      rd_data_o = '0;
      rd_busy_o = '0;
    end
  end

endmodule
